// File: rtl/arbiter_types.sv
// State and grant encodings for the shared memory-port arbiter.
package arbiter_types;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;
endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I datapath word type.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: count advances on inc and sticks at all-ones.
// Latency: count reflects inc one cycle later; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data sides.
// Latency: 1 cycle request-to-command, 0 cycles mem_resp-to-resp; requesters hold requests until resp.
module mem_port_arbiter
    import arbiter_types::*;
    import rv32i_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic [31:0]      imem_address,
    output logic [31:0]      imem_rdata,
    output logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic [31:0]      dmem_address,
    input  logic [31:0]      dmem_wdata,
    input  logic [3:0]       dmem_byte_enable,
    output logic [31:0]      dmem_rdata,
    output logic             dmem_resp,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_enable,
    input  logic             mem_resp,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] conflict_count
);
    arb_state_t state_q, state_d;
    arb_grant_t last_grant_q, last_grant_d;

    logic      i_req;
    logic      d_req;
    logic      conflict_inc;
    rv32i_word addr_sel;
    rv32i_word wdata_sel;

    assign i_req        = imem_read;
    assign d_req        = dmem_read | dmem_write;
    assign conflict_inc = (state_q == IDLE) && i_req && d_req;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        addr_sel        = '0;
        wdata_sel       = '0;
        mem_byte_enable = 4'h0;
        imem_resp       = 1'b0;
        dmem_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                // A tie goes to whichever side did not complete most recently.
                if (i_req && d_req) begin
                    state_d = (last_grant_q == GRANT_I) ? SERVE_D : SERVE_I;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                mem_read        = 1'b1;
                addr_sel        = imem_address;
                mem_byte_enable = 4'hF;
                imem_resp       = mem_resp;
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            SERVE_D: begin
                // Read and write together resolve to a write.
                mem_write       = dmem_write;
                mem_read        = dmem_read & ~dmem_write;
                addr_sel        = dmem_address;
                wdata_sel       = dmem_wdata;
                mem_byte_enable = dmem_byte_enable;
                dmem_resp       = mem_resp;
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_address = addr_sel;
    assign mem_wdata   = wdata_sel;
    assign imem_rdata  = mem_rdata;
    assign dmem_rdata  = mem_rdata;

    sat_counter #(
        .W(CNT_W)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (conflict_inc),
        .count (conflict_count)
    );
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the conflict counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_read  input  1  instruction-side read request, held until imem_resp.
REQ-005 SHALL have port imem_address  input  32  instruction-side address, stable while imem_read is high.
REQ-006 SHALL have port imem_rdata  output  32  instruction-side read data.
REQ-007 SHALL have port imem_resp  output  1  instruction-side one-cycle completion pulse.
REQ-008 SHALL have ports dmem_read and dmem_write  input  1 each  data-side requests, held until dmem_resp.
REQ-009 SHALL have ports dmem_address and dmem_wdata  input  32 each; dmem_byte_enable  input  4; all stable while a request is held.
REQ-010 SHALL have port dmem_rdata  output  32  and dmem_resp  output  1  data-side read data and completion pulse.
REQ-011 SHALL have ports mem_read and mem_write  output  1 each  shared memory-port commands.
REQ-012 SHALL have ports mem_address and mem_wdata  output  32 each; mem_byte_enable  output  4.
REQ-013 SHALL have ports mem_resp  input  1  and mem_rdata  input  32  shared-port completion and read data.
REQ-014 SHALL have port conflict_count  output  CNT_W  saturating count of cycles in which both sides requested in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SERVE_I and SERVE_D.
REQ-016 In IDLE, only imem_read high: SHALL move to SERVE_I next cycle.
REQ-017 In IDLE, only dmem_read or dmem_write high: SHALL move to SERVE_D next cycle.
REQ-018 In IDLE, both sides requesting: SHALL grant the side not served last (round-robin last_grant bit), increment conflict_count and stay saturated at all-ones.
REQ-019 In SERVE_x, SHALL drive the memory port from side x: mem_read/mem_write, address, wdata and byte_enable pass through combinationally from the granted inputs.
REQ-020 In SERVE_I, SHALL drive mem_write=0, mem_byte_enable=4'hF and mem_wdata=0.
REQ-021 In IDLE, SHALL drive mem_read=0, mem_write=0, mem_address=0, mem_wdata=0 and mem_byte_enable=0.
REQ-022 SHALL route mem_resp combinationally to the granted side's resp only; the other resp stays 0.
REQ-023 SHALL drive imem_rdata and dmem_rdata equal to mem_rdata at all times; each side qualifies the data with its own resp.
REQ-024 On mem_resp in SERVE_x, SHALL return to IDLE next cycle and set last_grant to x.
REQ-025 SHALL pass no request to the port in the cycle after a completion (the mandatory IDLE cycle), so a requester that drops its request after resp is never served twice.
REQ-026 Request-to-command latency SHALL be exactly 1 cycle from IDLE; completion-to-resp latency SHALL be 0 cycles.
REQ-027 dmem_read and dmem_write both high SHALL be treated as a write: mem_write=1 and mem_read=0.
REQ-028 mem_resp arriving in IDLE SHALL be ignored: no resp output and no state change.
REQ-029 A requester dropping its request mid-service (a protocol violation) SHALL NOT abort the service; the FSM stays in SERVE_x until mem_resp.

Reset
REQ-030 When rst=0 at a clock edge, SHALL enter IDLE, set last_grant=I (so data wins the first conflict), and clear conflict_count.
REQ-031 A reset during SERVE_x SHALL abandon the transfer; all mem_* commands and resp outputs SHALL read 0 the cycle after the reset edge.

Structure
REQ-032 The state enum (arb_state_t) and grant enum (arb_grant_t) SHALL live in shared package arbiter_types; rv32i_word SHALL come from rv32i_types.
REQ-033 The conflict counter SHALL be sub-module sat_counter (parameter W, inputs clk, rst, inc; output count).

Verification
REQ-034 Imem_read alone at address 0x0000_0040; mem_resp 3 cycles later with rdata 0x0000_0013 -> mem_read rises 1 cycle after request; imem_resp pulses with imem_rdata=0x13; dmem_resp=0.
REQ-035 Simultaneous requests out of reset (I read 0x40, D write 0x100, be=4'h3) -> D served first with mem_write=1 and mem_byte_enable=4'h3; after one IDLE cycle, I is served; conflict_count=1.
REQ-036 Back-to-back conflicts x4 -> grants alternate D,I,D,I,... and conflict_count=4; no request is served twice.
REQ-037 mem_resp pulsed in IDLE with no requests -> no resp output, state stays IDLE.
REQ-038 rst=0 asserted mid SERVE_D -> next cycle mem_write=0 and dmem_resp=0; conflict_count=0; first conflict after reset grants D.
